// File: rtl/num_ascii_serializer.sv
// -----------------------------------------------------------------------------
// num_ascii_serializer
//
// Purpose:
//   Captures a DATA_W-bit ALU result and streams it to a UART transmitter as
//   ASCII text, one byte per transmit handshake, most significant character
//   first. Decimal (optionally signed) or uppercase hexadecimal rendering,
//   leading-zero suppression, and an optional terminator byte.
//
// Ports:
//   clk              in   1       system clock, rising edge
//   reset            in   1       synchronous, active-high
//   alu_in           in   DATA_W  value to print, sampled on the accepted start
//   start_conversion in   1       start request (level or pulse), IDLE only
//   hex_mode         in   1       sampled with alu_in: 0 decimal, 1 hex
//   tx_done          in   1       UART idle flag (1 idle, 0 transmitting)
//   value_to_send    out  8       ASCII byte presented to the UART
//   tx_start         out  1       one-cycle transmit request
//   busy             out  1       high from accepted start until done
//   done             out  1       one-cycle pulse after the final byte
//
// DATA_W must be a multiple of 4 in the range 8..64.
// -----------------------------------------------------------------------------
module num_ascii_serializer #(
  parameter int         DATA_W    = 32,
  parameter bit         SIGNED_EN = 1'b1,
  parameter bit         TERM_EN   = 1'b1,
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_in,
  input  logic              start_conversion,
  input  logic              hex_mode,
  input  logic              tx_done,
  output logic [7:0]        value_to_send,
  output logic              tx_start,
  output logic              busy,
  output logic              done
);

  // ceil(DATA_W * log10(2)); the product is never an integer, so a scaled
  // integer ceiling is exact over the supported width range.
  localparam int DEC_DIGITS = (DATA_W * 30103 + 99999) / 100000;
  localparam int HEX_DIGITS = DATA_W / 4;
  localparam int MAX_CHARS  = DEC_DIGITS + 2;
  localparam int IDX_W      = $clog2(MAX_CHARS + 1);
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam int BCD_W      = DEC_DIGITS * 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              conv_done_q, conv_done_d;
  logic              hex_q, hex_d;
  logic              sign_q, sign_d;
  logic [IDX_W-1:0]  ndig_q, ndig_d;
  logic [IDX_W-1:0]  total_q, total_d;
  logic [IDX_W-1:0]  char_idx_q, char_idx_d;
  logic [7:0]        value_q, value_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  assign value_to_send = value_q;
  assign tx_start      = tx_start_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // ---------------------------------------------------------------------------
  // Capture-time sign and magnitude. The magnitude of the most negative value
  // (2^(DATA_W-1)) is still representable as an unsigned DATA_W number.
  // ---------------------------------------------------------------------------
  logic              in_sign;
  logic [DATA_W-1:0] in_neg;
  logic [DATA_W-1:0] in_mag;

  assign in_sign = SIGNED_EN && !hex_mode && alu_in[DATA_W-1];
  assign in_neg  = (~alu_in) + {{(DATA_W-1){1'b0}}, 1'b1};
  assign in_mag  = in_sign ? in_neg : alu_in;

  // ---------------------------------------------------------------------------
  // Per-digit logic: double-dabble add-3 correction, nonzero flag for
  // leading-zero suppression, and the ASCII code of each digit.
  // ---------------------------------------------------------------------------
  logic [BCD_W-1:0]      bcd_adj;
  logic [DEC_DIGITS-1:0] digit_nz;
  logic [7:0]            digit_char [DEC_DIGITS];

  generate
    for (genvar gi = 0; gi < DEC_DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      assign d                     = bcd_q[4*gi +: 4];
      assign bcd_adj[4*gi +: 4]    = (d >= 4'd5) ? (d + 4'd3) : d;
      assign digit_nz[gi]          = (d != 4'd0);
      // 0-9 -> '0'..'9', 10-15 -> 'A'..'F' ('A' - 10 = 8'h37)
      assign digit_char[gi]        = (d < 4'd10) ? (8'h30 + {4'h0, d})
                                                 : (8'h37 + {4'h0, d});
    end
  endgenerate

  // The top bit of the corrected vector is shifted out and never needed:
  // the digit count is sized so the top digit cannot overflow.
  logic unused_bcd_top;
  assign unused_bcd_top = bcd_adj[BCD_W-1];

  // Number of significant digits; an all-zero buffer still prints one '0'.
  logic [IDX_W-1:0] ndig_calc;
  always_comb begin
    ndig_calc = IDX_W'(1);
    for (int i = 0; i < DEC_DIGITS; i++) begin
      if (digit_nz[i]) ndig_calc = IDX_W'(i + 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Character selection for the current emission index:
  //   [optional '-'] [ndig digits, MSB first] [optional terminator]
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] char_pos;
  logic [IDX_W-1:0] digit_sel;
  logic [7:0]       sel_char;
  logic [7:0]       cur_char;

  always_comb begin
    char_pos  = char_idx_q - IDX_W'(sign_q);
    digit_sel = ndig_q - char_pos - IDX_W'(1);
    sel_char  = 8'h30;
    for (int k = 0; k < DEC_DIGITS; k++) begin
      if (digit_sel == IDX_W'(k)) sel_char = digit_char[k];
    end
    if (sign_q && (char_idx_q == '0)) begin
      cur_char = 8'h2D;
    end else if (char_pos < ndig_q) begin
      cur_char = sel_char;
    end else begin
      cur_char = TERM_CHAR;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    bit_cnt_d   = bit_cnt_q;
    conv_done_d = conv_done_q;
    hex_d       = hex_q;
    sign_d      = sign_q;
    ndig_d      = ndig_q;
    total_d     = total_q;
    char_idx_d  = char_idx_q;
    value_d     = value_q;
    busy_d      = busy_q;
    tx_start_d  = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_conversion) begin
          hex_d       = hex_mode;
          sign_d      = in_sign;
          shift_d     = in_mag;
          bcd_d       = '0;
          bit_cnt_d   = '0;
          conv_done_d = 1'b0;
          char_idx_d  = '0;
          busy_d      = 1'b1;
          state_d     = S_CONVERT;
        end
      end

      S_CONVERT: begin
        if (!conv_done_q) begin
          if (hex_q) begin
            // Nibbles are already hex digits; load them in one step.
            bcd_d       = {{(BCD_W - 4*HEX_DIGITS){1'b0}}, shift_q};
            conv_done_d = 1'b1;
          end else begin
            // One double-dabble iteration: correct, then shift in next bit.
            bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              conv_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end else begin
          // Digits are final: fix the emission length and start sending.
          ndig_d     = ndig_calc;
          total_d    = ndig_calc + IDX_W'(sign_q) + IDX_W'(TERM_EN);
          char_idx_d = '0;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        if (tx_done) begin
          value_d    = cur_char;
          tx_start_d = 1'b1;
          state_d    = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        if (!tx_done) state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (tx_done) state_d = S_NEXT;
      end

      S_NEXT: begin
        char_idx_d = char_idx_q + IDX_W'(1);
        if ((char_idx_q + IDX_W'(1)) < total_q) begin
          state_d = S_SEND;
        end else begin
          // done and busy change together so the pulse marks the busy fall.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bcd_q       <= '0;
      bit_cnt_q   <= '0;
      conv_done_q <= 1'b0;
      hex_q       <= 1'b0;
      sign_q      <= 1'b0;
      ndig_q      <= '0;
      total_q     <= '0;
      char_idx_q  <= '0;
      value_q     <= 8'h00;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      bit_cnt_q   <= bit_cnt_d;
      conv_done_q <= conv_done_d;
      hex_q       <= hex_d;
      sign_q      <= sign_d;
      ndig_q      <= ndig_d;
      total_q     <= total_d;
      char_idx_q  <= char_idx_d;
      value_q     <= value_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_num_ascii_serializer.sv
// -----------------------------------------------------------------------------
// tb_num_ascii_serializer
//
// Self-checking bench for num_ascii_serializer (default parameters: 32-bit,
// signed decimal, newline terminator). A UART model drops tx_done for a
// programmable number of cycles after each tx_start and records the bytes.
// Expected byte streams come from a reference model that formats the number
// with ordinary integer division.
// -----------------------------------------------------------------------------
module tb_num_ascii_serializer;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] alu_in = '0;
  logic        start_conversion = 1'b0;
  logic        hex_mode = 1'b0;
  logic        tx_done = 1'b1;
  logic [7:0]  value_to_send;
  logic        tx_start;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  num_ascii_serializer dut (
    .clk              (clk),
    .reset            (reset),
    .alu_in           (alu_in),
    .start_conversion (start_conversion),
    .hex_mode         (hex_mode),
    .tx_done          (tx_done),
    .value_to_send    (value_to_send),
    .tx_start         (tx_start),
    .busy             (busy),
    .done             (done)
  );

  // ---------------------------------------------------------------------------
  // UART model and monitor (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  bq_t  rx_q;
  int   pulse_cnt = 0;
  int   done_cnt = 0;
  int   uart_cnt = 0;
  int   uart_len = 15;
  bit   tx_force_low = 1'b0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    if (tx_start) begin
      rx_q.push_back(value_to_send);
      if (!prev_start) pulse_cnt++;
      uart_cnt = uart_len;
    end
    prev_start = tx_start;
    if (done) done_cnt++;
    tx_done = (uart_cnt == 0) && !tx_force_low;
    if (uart_cnt > 0) uart_cnt--;
  end

  // ---------------------------------------------------------------------------
  // Reference model: text rendering of a 32-bit value
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] to_ascii(input int unsigned d);
    logic [7:0] c;
    if (d < 10) c = 8'(48 + d);      // '0' + d
    else        c = 8'(65 + d - 10); // 'A' + d - 10
    return c;
  endfunction

  function automatic bq_t model_bytes(input logic [31:0] v, input bit hx);
    bq_t             q;
    bq_t             digs;
    longint unsigned m;
    int unsigned     base;
    bit              neg;
    neg  = !hx && v[31];
    m    = {32'd0, v};
    if (neg) m = 64'd4294967296 - m;
    base = hx ? 16 : 10;
    do begin
      digs.push_front(to_ascii(int'(m % base)));
      m = m / base;
    end while (m != 0);
    if (neg) q.push_back(8'h2D);
    foreach (digs[i]) q.push_back(digs[i]);
    q.push_back(8'h0A);
    return q;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------------
  task automatic clear_mon();
    @(negedge clk);
    rx_q.delete();
    pulse_cnt = 0;
    done_cnt  = 0;
  endtask

  task automatic start_pulse(input logic [31:0] v, input bit hx);
    @(negedge clk);
    alu_in           = v;
    hex_mode         = hx;
    start_conversion = 1'b1;
    @(negedge clk);
    start_conversion = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (value_to_send !== 8'h00) begin
      errors++; $display("FAIL reset_value got=%h exp=00", value_to_send);
    end
    checks++;
    if (tx_start !== 1'b0) begin
      errors++; $display("FAIL reset_tx_start got=%b exp=0", tx_start);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%b exp=0", done);
    end
    reset = 1'b0;
    $display("reset: outputs idle after synchronous reset");
  endtask

  // One full conversion checked byte by byte, plus pulse/done/busy counts.
  task automatic test_conversion(input string name, input logic [31:0] v,
                                 input bit hx);
    bq_t exp_q;
    bit  ok;
    clear_mon();
    exp_q = model_bytes(v, hx);
    start_pulse(v, hx);
    wait_done(3000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s timeout got=no_done exp=done", name);
    end
    @(negedge clk);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s byte_count got=%0d exp=%0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s byte[%0d] got=%h exp=%h", name, i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pulse_cnt != exp_q.size()) begin
      errors++;
      $display("FAIL %s tx_start_pulses got=%0d exp=%0d", name, pulse_cnt, exp_q.size());
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_after got=%b exp=0", name, busy);
    end
    $display("conv %s value=%h hex=%0d bytes=%0d", name, v, hx, rx_q.size());
  endtask

  task automatic test_handshake();
    bq_t         exp_q;
    bit          ok;
    logic [31:0] v;
    v = 32'd987654;
    exp_q = model_bytes(v, 1'b0);
    uart_len = 6;
    clear_mon();
    tx_force_low = 1'b1;
    @(negedge clk);
    start_pulse(v, 1'b0);
    repeat (60) @(negedge clk);
    checks++;
    if (pulse_cnt != 0) begin
      errors++; $display("FAIL hs_blocked tx_start_pulses got=%0d exp=0", pulse_cnt);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL hs_blocked busy got=%b exp=1", busy);
    end
    tx_force_low = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rx_q.size() >= 3) break;
    end
    // A new request mid-stream must not disturb the running conversion.
    start_pulse(32'd43, 1'b0);
    wait_done(3000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL hs timeout got=no_done exp=done");
    end
    @(negedge clk);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL hs byte_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL hs byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL hs done_pulses got=%0d exp=1", done_cnt);
    end
    $display("handshake: held tx_done then mid-stream start, bytes=%0d", rx_q.size());
  endtask

  task automatic test_reset_mid();
    int n;
    uart_len = 15;
    clear_mon();
    start_pulse(32'd1234567898, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rx_q.size() >= 4) break;
    end
    checks++;
    if (rx_q.size() < 4) begin
      errors++; $display("FAIL rst_mid reach_byte4 got=%0d exp=4", rx_q.size());
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (tx_start !== 1'b0) begin
      errors++; $display("FAIL rst_mid tx_start got=%b exp=0", tx_start);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid busy got=%b exp=0", busy);
    end
    checks++;
    if (value_to_send !== 8'h00) begin
      errors++; $display("FAIL rst_mid value got=%h exp=00", value_to_send);
    end
    n = rx_q.size();
    repeat (60) @(negedge clk);
    checks++;
    if (rx_q.size() != n) begin
      errors++; $display("FAIL rst_mid extra_bytes got=%0d exp=%0d", rx_q.size(), n);
    end
    $display("reset_mid: aborted after %0d bytes", n);
    test_conversion("after_reset_43", 32'd43, 1'b0);
  endtask

  task automatic test_back_to_back();
    bq_t         exp_q;
    bq_t         exp_b;
    bit          ok;
    logic [31:0] va;
    logic [31:0] vb;
    va = $urandom;
    vb = $urandom;
    exp_q = model_bytes(va, 1'b0);
    exp_b = model_bytes(vb, 1'b1);
    foreach (exp_b[i]) exp_q.push_back(exp_b[i]);
    uart_len = 2;
    clear_mon();
    @(negedge clk);
    alu_in = va; hex_mode = 1'b0; start_conversion = 1'b1;
    wait_done(3000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b first_timeout got=no_done exp=done");
    end
    alu_in = vb; hex_mode = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b restart_busy got=%b exp=1", busy);
    end
    start_conversion = 1'b0;
    wait_done(3000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b second_timeout got=no_done exp=done");
    end
    @(negedge clk);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b byte_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 2) begin
      errors++; $display("FAIL b2b done_pulses got=%0d exp=2", done_cnt);
    end
    $display("back_to_back: a=%h b=%h bytes=%0d", va, vb, rx_q.size());
  endtask

  task automatic test_random();
    logic [31:0] v;
    bit          hx;
    for (int n = 0; n < 24; n++) begin
      v  = $urandom;
      v  = v >> $urandom_range(0, 31);   // spread magnitudes for zero suppression
      if ($urandom_range(0, 2) == 0) v = ~v;
      hx = 1'($urandom_range(0, 1));
      uart_len = $urandom_range(1, 4);
      test_conversion("random", v, hx);
    end
  endtask

  initial begin
    test_reset();
    uart_len = 15;
    test_conversion("dec_1234567898", 32'd1234567898, 1'b0);
    uart_len = 3;
    test_conversion("dec_43", 32'd43, 1'b0);
    test_conversion("dec_zero", 32'd0, 1'b0);
    test_conversion("neg_5", 32'hFFFFFFFB, 1'b0);
    test_conversion("most_negative", 32'h80000000, 1'b0);
    test_conversion("hex_abcdef", 32'h00ABCDEF, 1'b1);
    test_conversion("hex_fffffffb", 32'hFFFFFFFB, 1'b1);
    test_conversion("hex_zero", 32'h0, 1'b1);
    test_conversion("dec_max_pos", 32'h7FFFFFFF, 1'b0);
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
